hazard_forward_detect_unit: RTL and testbench
=============================================

// Module: hazard_forward_detect_unit
// PURPOSE
//  Upstream of FORWARDING_CONTROL_UNIT: tracks rd/write-enable of in-flight instructions (EX, MEM, WB shadow
//  entries) and drives its MEM_FORWARD_EN / WB_FORWARD_EN, registered into the ID/EX boundary.
//  Also detects load-use and multicycle MUL/DIV hazards and issues pipeline stall/bubble/hold controls.
// PARAMETERS
//  REG_ADDR_W     5   register address width
//  MULDIV_CYCLES  4   EX-stage cycles of a MUL/DIV op, legal 1..32 (1 = no stall)
// PORTS
//  CLK              in   1  clock, rising edge
//  RESET_N          in   1  asynchronous, active-low reset
//  ID_VALID         in   1  ID holds a real instruction
//  ID_RS1_ADDR      in   5  source reg 1 of ID instruction
//  ID_RS2_ADDR      in   5  source reg 2
//  ID_RS1_USED      in   1  rs1 read by instruction
//  ID_RS2_USED      in   1  rs2 read by instruction
//  ID_RD_ADDR       in   5  destination reg
//  ID_REG_WRITE_EN  in   1  instruction writes rd
//  ID_MEM_READ      in   1  instruction is a load
//  ID_MULDIV        in   1  instruction is MUL/DIV/REM
//  FLUSH            in   1  branch/jump taken in EX: kill ID instruction
//  MEM_FORWARD_EN   out  2  bit0 op1, bit1 op2: forward MEM result (registered)
//  WB_FORWARD_EN    out  2  bit0 op1, bit1 op2: forward WB result (registered)
//  STALL            out  1  hold PC and IF/ID (combinational)
//  BUBBLE           out  1  load NOP into ID/EX (combinational)
//  EX_HOLD          out  1  hold ID/EX and EX stage, MUL/DIV busy (combinational)
// BEHAVIOUR
//  - Reset (async, RESET_N=0): EX/MEM/WB entries invalid, both FORWARD_EN=2'b00, state IDLE, counter 0;
//    STALL/BUBBLE/EX_HOLD=0 while in reset. Reset mid-MUL/DIV aborts it.
//  - Entry = {valid, rd, we, is_load}; entry "writes r" iff valid & we & rd==r & rd!=0 (x0 never forwarded).
//  - load_hazard = ID_VALID & !FLUSH & EX entry is_load & writes (rs1 if RS1_USED or rs2 if RS2_USED).
//  - busy = (state==MULDIV) & (cnt!=0). STALL = busy | load_hazard; EX_HOLD = busy;
//    BUBBLE = !busy & (load_hazard | FLUSH | !ID_VALID).
//  - Per-edge update, priority busy > load_hazard > normal:
//    busy: EX entry holds, MEM<=invalid, WB<=MEM, cnt<=cnt-1 (IDLE at 0), FORWARD_EN<=00 (MUL/DIV unit
//      latched operands on its first EX cycle). FLUSH ignored while busy.
//    load_hazard: EX<=invalid, MEM<=EX, WB<=MEM, FORWARD_EN<=00. Exactly one stall cycle: next cycle the
//      load sits in MEM, hazard clears, consumer gets WB_FORWARD_EN on following edge.
//    normal: EX<=ID fields (invalid if FLUSH|!ID_VALID), MEM<=EX, WB<=MEM. Per operand n (if USED):
//      MEM_FORWARD_EN[n]<=current EX writes rs_n; WB_FORWARD_EN[n]<=current MEM writes rs_n & !MEM bit
//      (MEM has priority; MEM and WB bits never both set for one operand). Killed/invalid ID -> 00.
//      If ID_MULDIV & ID_VALID & !FLUSH & MULDIV_CYCLES>1: state<=MULDIV, cnt<=MULDIV_CYCLES-1.
//  - Hazard with instruction 3 ahead (in WB now) not forwarded: register file is write-before-read.
//  - Latency: forward enables valid the cycle the consumer is in EX (1 edge after ID).
// STRUCTURE
//  - Package pipe_ctrl_pkg: shadow entry struct, FWD_OP1=0/FWD_OP2=1 bit indices, state enum {IDLE,MULDIV},
//    REG_ADDR_W constant, counter width $clog2(MULDIV_CYCLES+1).
//  - One sub-module fwd_reg_match: entry + rs addr + used -> match bit (instanced 4x, plus 2x load check).
// TESTING (default params; op results in next listed cycle)
//  1. add x5,.. then add x6,x5,x1 -> consumer EX cycle: MEM_FORWARD_EN=01, WB_FORWARD_EN=00, STALL=0.
//  2. add x5,..; nop; sub x7,x2,x5 -> WB_FORWARD_EN=10, MEM_FORWARD_EN=00.
//  3. add x7; add x7; and x8,x7,x7 -> MEM_FORWARD_EN=11, WB_FORWARD_EN=00; rd=x0 or we=0 producer -> 00/00.
//  4. lw x3; add x4,x3,x3 -> STALL=1,BUBBLE=1 one cycle, then WB_FORWARD_EN=11, MEM=00; same with FLUSH=1
//     -> STALL=0, BUBBLE=1, enables 00.
//  5. mul x9 -> STALL=EX_HOLD=1 for exactly 3 cycles, enables 00; dependent add x1,x9 afterwards gets
//     MEM_FORWARD_EN=01.
//  6. RESET_N=0 during 2nd busy cycle -> STALL/EX_HOLD/BUBBLE=0 and enables 00 immediately; after release,
//     add x5 then use x5 -> MEM_FORWARD_EN=01 (no stale entries).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard/forward control slice
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_OP1    = 0;
  localparam int FWD_OP2    = 1;

  typedef enum logic {
    IDLE,
    MULDIV
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } shadow_entry_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  // x0 is hardwired zero, so an entry targeting it never produces a forwardable value
  function automatic logic entry_writes(input shadow_entry_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid & e.we & (e.rd == r) & (e.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_reg_match.sv
// rtl/fwd_reg_match.sv - flags when a shadow entry produces a source register the ID instruction reads
module fwd_reg_match
  import pipe_ctrl_pkg::*;
(
  input  shadow_entry_t         entry,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic                  rs_used,
  output logic                  match
);

  assign match = rs_used & entry_writes(entry, rs_addr);

endmodule

// File: rtl/hazard_forward_detect_unit.sv
// rtl/hazard_forward_detect_unit.sv - tracks in-flight destinations, registers forward enables into ID/EX,
// and raises stall/bubble/hold for load-use and multicycle MUL/DIV hazards
module hazard_forward_detect_unit #(
  parameter int REG_ADDR_W    = 5,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write_en,
  input  logic                  id_mem_read,
  input  logic                  id_muldiv,
  input  logic                  flush,
  output logic [1:0]            mem_forward_en,
  output logic [1:0]            wb_forward_en,
  output logic                  stall,
  output logic                  bubble,
  output logic                  ex_hold
);
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = cnt_width(MULDIV_CYCLES);

  // No WB shadow is kept: the register file is write-before-read, so WB producers never need forwarding
  shadow_entry_t ex_entry, mem_entry, ex_next, mem_next, id_entry, ex_load_entry;
  state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]    mem_fwd_next, wb_fwd_next;
  logic [1:0]    ex_match, mem_match, load_match;
  logic [1:0]    rs_used;
  logic [REG_ADDR_W-1:0] rs_addr [2];
  logic          id_live, busy, load_hazard;

  assign id_live = id_valid & ~flush;
  assign id_entry = '{valid: id_live, rd: id_rd_addr, we: id_reg_write_en, is_load: id_mem_read};
  assign ex_load_entry = '{valid: ex_entry.valid & ex_entry.is_load, rd: ex_entry.rd,
                           we: ex_entry.we, is_load: ex_entry.is_load};

  assign rs_addr[FWD_OP1] = id_rs1_addr;
  assign rs_addr[FWD_OP2] = id_rs2_addr;
  assign rs_used[FWD_OP1] = id_rs1_used;
  assign rs_used[FWD_OP2] = id_rs2_used;

  for (genvar n = 0; n < 2; n++) begin : g_op
    fwd_reg_match u_ex_match (
      .entry(ex_entry), .rs_addr(rs_addr[n]), .rs_used(rs_used[n]), .match(ex_match[n])
    );
    fwd_reg_match u_mem_match (
      .entry(mem_entry), .rs_addr(rs_addr[n]), .rs_used(rs_used[n]), .match(mem_match[n])
    );
    fwd_reg_match u_load_match (
      .entry(ex_load_entry), .rs_addr(rs_addr[n]), .rs_used(rs_used[n]), .match(load_match[n])
    );
  end

  assign busy        = (state == MULDIV) && (cnt != '0);
  assign load_hazard = id_live & (|load_match);

  // Held low during reset so the pipeline sees no spurious stall/bubble while registers are cleared
  assign stall   = reset_n & (busy | load_hazard);
  assign ex_hold = reset_n & busy;
  assign bubble  = reset_n & ~busy & (load_hazard | flush | ~id_valid);

  always_comb begin
    ex_next      = ex_entry;
    mem_next     = mem_entry;
    state_next   = state;
    cnt_next     = cnt;
    mem_fwd_next = 2'b00;
    wb_fwd_next  = 2'b00;
    if (busy) begin
      mem_next = '0;
      cnt_next = cnt - 1'b1;
      if (cnt == CNT_W'(1)) state_next = IDLE;
    end else if (load_hazard) begin
      ex_next  = '0;
      mem_next = ex_entry;
    end else begin
      ex_next    = id_entry;
      mem_next   = ex_entry;
      state_next = IDLE;
      if (id_live) begin
        mem_fwd_next = ex_match;
        wb_fwd_next  = mem_match & ~ex_match;
        if (id_muldiv && (MULDIV_CYCLES > 1)) begin
          state_next = MULDIV;
          cnt_next   = CNT_W'(MULDIV_CYCLES - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_entry       <= '0;
      mem_entry      <= '0;
      state          <= IDLE;
      cnt            <= '0;
      mem_forward_en <= 2'b00;
      wb_forward_en  <= 2'b00;
    end else begin
      ex_entry       <= ex_next;
      mem_entry      <= mem_next;
      state          <= state_next;
      cnt            <= cnt_next;
      mem_forward_en <= mem_fwd_next;
      wb_forward_en  <= wb_fwd_next;
    end
  end

endmodule

// File: tb/tb_hazard_forward_detect_unit.sv
// tb/tb_hazard_forward_detect_unit.sv - directed self-checking bench for hazard_forward_detect_unit
module tb_hazard_forward_detect_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       id_rs1_used, id_rs2_used;
  logic       id_reg_write_en, id_mem_read, id_muldiv, flush;
  logic [1:0] mem_forward_en, wb_forward_en;
  logic       stall, bubble, ex_hold;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_forward_detect_unit #(.REG_ADDR_W(5), .MULDIV_CYCLES(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd_addr     (id_rd_addr),
    .id_reg_write_en(id_reg_write_en),
    .id_mem_read    (id_mem_read),
    .id_muldiv      (id_muldiv),
    .flush          (flush),
    .mem_forward_en (mem_forward_en),
    .wb_forward_en  (wb_forward_en),
    .stall          (stall),
    .bubble         (bubble),
    .ex_hold        (ex_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic s, input logic b, input logic h);
    check({tag, ".stall"}, {1'b0, stall}, {1'b0, s});
    check({tag, ".bubble"}, {1'b0, bubble}, {1'b0, b});
    check({tag, ".ex_hold"}, {1'b0, ex_hold}, {1'b0, h});
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] m, input logic [1:0] w);
    check({tag, ".mem_fwd"}, mem_forward_en, m);
    check({tag, ".wb_fwd"}, wb_forward_en, w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic we, input logic ld, input logic md,
                       input logic fl);
    id_valid = v; id_rd_addr = rd; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_rs1_used = u1; id_rs2_used = u2; id_reg_write_en = we;
    id_mem_read = ld; id_muldiv = md; flush = fl;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    nop();
    tick();
    tick();
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_fwd("reset", 2'b00, 2'b00);
    reset_n = 1'b1;
    #1;
    check_ctl("idle_nop", 1'b0, 1'b1, 1'b0);

    // 1: back-to-back dependency through MEM on op1
    alu(5'd5, 5'd1, 5'd2);
    tick();
    alu(5'd6, 5'd5, 5'd1);
    check_ctl("t1_id", 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    check_fwd("t1_ex", 2'b01, 2'b00);

    // 2: one instruction gap, producer forwarded from WB on op2
    alu(5'd5, 5'd1, 5'd2);
    tick();
    nop();
    tick();
    alu(5'd7, 5'd2, 5'd5);
    tick();
    nop();
    check_fwd("t2_ex", 2'b00, 2'b10);

    // 3: two producers of x7, nearer one (MEM forward) wins on both operands
    alu(5'd7, 5'd1, 5'd2);
    tick();
    alu(5'd7, 5'd3, 5'd4);
    tick();
    alu(5'd8, 5'd7, 5'd7);
    tick();
    check_fwd("t3_ex", 2'b11, 2'b00);
    alu(5'd0, 5'd1, 5'd2);
    tick();
    alu(5'd10, 5'd0, 5'd0);
    tick();
    check_fwd("t3_x0", 2'b00, 2'b00);
    drive(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    alu(5'd11, 5'd9, 5'd9);
    tick();
    nop();
    check_fwd("t3_we0", 2'b00, 2'b00);
    tick();
    tick();

    // 4: load-use costs exactly one stall, then WB forward on both operands
    drive(1'b1, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    alu(5'd4, 5'd3, 5'd3);
    check_ctl("t4_stall", 1'b1, 1'b1, 1'b0);
    tick();
    check_ctl("t4_after", 1'b0, 1'b0, 1'b0);
    check_fwd("t4_bubble", 2'b00, 2'b00);
    tick();
    nop();
    check_fwd("t4_ex", 2'b00, 2'b11);
    tick();
    tick();
    drive(1'b1, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_ctl("t4_flush", 1'b0, 1'b1, 1'b0);
    tick();
    nop();
    check_fwd("t4_flush", 2'b00, 2'b00);
    tick();
    tick();

    // 5: MUL/DIV holds EX for MULDIV_CYCLES-1 cycles, then dependent gets MEM forward
    drive(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("t5_id", 1'b0, 1'b0, 1'b0);
    tick();
    alu(5'd1, 5'd9, 5'd2);
    for (int i = 0; i < 3; i++) begin
      check_ctl($sformatf("t5_busy%0d", i), 1'b1, 1'b0, 1'b1);
      check_fwd($sformatf("t5_busy%0d", i), 2'b00, 2'b00);
      tick();
    end
    check_ctl("t5_done", 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    check_fwd("t5_ex", 2'b01, 2'b00);
    tick();
    tick();

    // 6: reset during the second busy cycle aborts the MUL/DIV and clears shadows
    drive(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    nop();
    check_ctl("t6_busy1", 1'b1, 1'b0, 1'b1);
    tick();
    reset_n = 1'b0;
    #1;
    check_ctl("t6_rst", 1'b0, 1'b0, 1'b0);
    check_fwd("t6_rst", 2'b00, 2'b00);
    tick();
    reset_n = 1'b1;
    alu(5'd5, 5'd1, 5'd2);
    check_ctl("t6_post", 1'b0, 1'b0, 1'b0);
    tick();
    alu(5'd6, 5'd5, 5'd1);
    check_ctl("t6_use", 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    check_fwd("t6_ex", 2'b01, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
